// File: rtl/apb4_slave_regfile.sv
// APB4 completer backed by a word-organised register array with byte strobes,
// programmable wait states and PSLVERR on misaligned, out-of-range or unprivileged accesses.
module apb4_slave_regfile #(
   parameter int unsigned PADDR_SIZE  = 16,
   parameter int unsigned PDATA_SIZE  = 32,
   parameter int unsigned MEM_WORDS   = 64,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PRIV_ONLY   = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [2:0]              PPROT,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int unsigned NumLanes = PDATA_SIZE / 8;
   localparam int unsigned BL       = $clog2(NumLanes);
   localparam int unsigned WL       = $clog2(MEM_WORDS);
   localparam logic [PADDR_SIZE-1:0] AlignMask = PADDR_SIZE'((1 << BL) - 1);
   localparam logic [3:0] WaitInit  = 4'(WAIT_STATES);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic                    err_q;
   logic [PDATA_SIZE-1:0]   prdata_q;
   logic                    pready_q;
   logic                    pslverr_q;
   logic [PDATA_SIZE-1:0]   mem_q [MEM_WORDS];

   logic [PADDR_SIZE-1:0]   addr_hi;
   logic [WL-1:0]           idx;
   logic                    misaligned;
   logic                    out_of_range;
   logic                    unpriv;
   logic                    err;
   logic                    unused_pprot;

   // Any address bit above the array span means the access falls outside it.
   assign addr_hi      = PADDR >> (BL + WL);
   assign out_of_range = |addr_hi;
   assign misaligned   = |(PADDR & AlignMask);
   assign unpriv       = (PRIV_ONLY != 0) && !PPROT[0];
   assign err          = misaligned || out_of_range || unpriv;
   assign idx          = PADDR[BL +: WL];
   assign unused_pprot = ^PPROT[2:1];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (PSEL && !PENABLE) begin
                  state_q   <= StAccess;
                  cnt_q     <= WaitInit;
                  err_q     <= err;
                  pready_q  <= (WAIT_STATES == 0);
                  pslverr_q <= err && (WAIT_STATES == 0);
                  prdata_q  <= (err || PWRITE) ? '0 : mem_q[idx];
               end
            end
            StAccess: begin
               if (!PSEL) begin
                  state_q   <= StIdle;
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     pready_q  <= 1'b1;
                     pslverr_q <= err_q;
                  end
               end else if (pready_q && PENABLE) begin
                  if (PWRITE && !err_q) begin
                     for (int unsigned i = 0; i < NumLanes; i++) begin
                        if (PSTRB[i]) begin
                           mem_q[idx][8*i +: 8] <= PWDATA[8*i +: 8];
                        end
                     end
                  end
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Bench for apb4_slave_regfile: three instances (0, 3 and 1 wait states, the last privileged-only)
// checked every cycle against a transaction-level model plus hand-computed read-back values.
module tb_apb4_slave_regfile;

   logic PCLK = 1'b0;
   logic PRESETn = 1'b1;
   always #5 PCLK = ~PCLK;

   logic        psel    [3];
   logic        penable [3];
   logic        pwrite  [3];
   logic [3:0]  pstrb   [3];
   logic [15:0] paddr   [3];
   logic [2:0]  pprot   [3];
   logic [31:0] pwdata  [3];
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // Model state: expected outputs for the current cycle and the expected array contents.
   logic        exp_rdy [3];
   logic        exp_err [3];
   logic [31:0] exp_rd  [3];
   logic [31:0] mem_m   [3][64];

   apb4_slave_regfile #(.PADDR_SIZE(16), .PDATA_SIZE(32), .MEM_WORDS(64), .WAIT_STATES(0),
                        .PRIV_ONLY(0)) u_dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PSTRB(pstrb[0]), .PADDR(paddr[0]), .PPROT(pprot[0]),
      .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   apb4_slave_regfile #(.PADDR_SIZE(16), .PDATA_SIZE(32), .MEM_WORDS(64), .WAIT_STATES(3),
                        .PRIV_ONLY(0)) u_dut1 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PSTRB(pstrb[1]), .PADDR(paddr[1]), .PPROT(pprot[1]),
      .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   apb4_slave_regfile #(.PADDR_SIZE(16), .PDATA_SIZE(32), .MEM_WORDS(64), .WAIT_STATES(1),
                        .PRIV_ONLY(1)) u_dut2 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable[2]),
      .PWRITE(pwrite[2]), .PSTRB(pstrb[2]), .PADDR(paddr[2]), .PPROT(pprot[2]),
      .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
   );

   function automatic int ws_of(input int k);
      return (k == 1) ? 3 : (k == 2) ? 1 : 0;
   endfunction

   function automatic bit model_err(input int k, input logic [15:0] addr, input logic [2:0] prot);
      return (addr % 4 != 0) || (addr >= 16'd256) || (k == 2 && !prot[0]);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge PCLK) begin
      if (cmp_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("pready[%0d]", k), 32'(pready[k]), 32'(exp_rdy[k]));
            chk($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(exp_rdy[k] && exp_err[k]));
            if (exp_rdy[k]) chk($sformatf("prdata[%0d]", k), prdata[k], exp_rd[k]);
         end
      end
   end

   // Called at posedge+1; drives setup immediately and returns at posedge+1 after completion,
   // so consecutive calls are back-to-back. Returns what the DUT showed in its ready cycle.
   task automatic xfer(input int k, input bit wr, input logic [15:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [2:0] prot,
                       output logic [31:0] got_rd, output logic got_err);
      bit          er;
      logic [31:0] rd;
      int          ws;
      ws = ws_of(k);
      er = model_err(k, addr, prot);
      rd = (er || wr) ? 32'h0 : mem_m[k][addr / 4 % 64];
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr;
      pstrb[k] = strb; pwdata[k] = wd; pprot[k] = prot;
      exp_rdy[k] = 1'b0;
      for (int j = 0; j <= ws; j++) begin
         @(posedge PCLK); #1;
         penable[k] = 1'b1;
         exp_rdy[k] = (j == ws);
         exp_err[k] = er;
         exp_rd[k]  = rd;
      end
      got_rd  = prdata[k];
      got_err = pslverr[k];
      @(posedge PCLK); #1;
      if (wr && !er) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_m[k][addr / 4 % 64][8*b +: 8] = wd[8*b +: 8];
         end
      end
      psel[k] = 1'b0; penable[k] = 1'b0;
      exp_rdy[k] = 1'b0;
   endtask

   task automatic start_write_k1(input logic [15:0] addr, input logic [31:0] wd);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = addr;
      pstrb[1] = 4'hF; pwdata[1] = wd; pprot[1] = 3'b001;
      @(posedge PCLK); #1;
      penable[1] = 1'b1;
      @(posedge PCLK); #1;
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      for (int k = 0; k < 3; k++) begin
         psel[k] = 0; penable[k] = 0; pwrite[k] = 0; pstrb[k] = 0; paddr[k] = 0;
         pprot[k] = 0; pwdata[k] = 0; exp_rdy[k] = 0; exp_err[k] = 0; exp_rd[k] = 0;
         for (int w = 0; w < 64; w++) mem_m[k][w] = 32'h0;
      end
      #3 PRESETn = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("reset pready", 32'(pready[k]), 32'h0);
         chk("reset pslverr", 32'(pslverr[k]), 32'h0);
         chk("reset prdata", prdata[k], 32'h0);
      end

      // Zero wait states: reads, strobed writes, errors, back-to-back.
      xfer(0, 0, 16'h0000, 4'h0, 32'h0, 3'b001, rd, er);
      chk("rd 0x0 data", rd, 32'h0);
      chk("rd 0x0 err", 32'(er), 32'h0);
      xfer(0, 1, 16'h0004, 4'b0101, 32'hDEADBEEF, 3'b001, rd, er);
      xfer(0, 0, 16'h0004, 4'h0, 32'h0, 3'b001, rd, er);
      chk("strobed rd 0x4", rd, 32'h00AD00EF);
      xfer(0, 1, 16'h0004, 4'b0000, 32'hFFFFFFFF, 3'b001, rd, er);
      xfer(0, 0, 16'h0004, 4'h0, 32'h0, 3'b001, rd, er);
      chk("strb0 rd 0x4", rd, 32'h00AD00EF);
      xfer(0, 1, 16'h0000, 4'hF, 32'h11111111, 3'b001, rd, er);
      xfer(0, 1, 16'h0100, 4'hF, 32'hFFFFFFFF, 3'b001, rd, er);
      chk("oor wr err", 32'(er), 32'h1);
      xfer(0, 0, 16'h0000, 4'h0, 32'h0, 3'b001, rd, er);
      chk("rd 0x0 after oor", rd, 32'h11111111);
      xfer(0, 0, 16'h0002, 4'h0, 32'h0, 3'b001, rd, er);
      chk("misaligned rd err", 32'(er), 32'h1);
      chk("misaligned rd data", rd, 32'h0);
      xfer(0, 1, 16'h000C, 4'hF, 32'hA5A55A5A, 3'b001, rd, er);
      xfer(0, 0, 16'h000C, 4'h0, 32'h0, 3'b001, rd, er);
      chk("b2b rd 0xC", rd, 32'hA5A55A5A);

      // Three wait states, misaligned write, abort.
      xfer(1, 1, 16'h0010, 4'hF, 32'h12345678, 3'b001, rd, er);
      xfer(1, 0, 16'h0010, 4'h0, 32'h0, 3'b001, rd, er);
      chk("ws3 rd 0x10", rd, 32'h12345678);
      xfer(1, 1, 16'h0011, 4'hF, 32'h0BADF00D, 3'b001, rd, er);
      chk("ws3 misaligned wr err", 32'(er), 32'h1);
      xfer(1, 0, 16'h0010, 4'h0, 32'h0, 3'b001, rd, er);
      chk("ws3 rd 0x10 unchanged", rd, 32'h12345678);
      start_write_k1(16'h0014, 32'hDDDDDDDD);
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(posedge PCLK); #1;
      xfer(1, 0, 16'h0014, 4'h0, 32'h0, 3'b001, rd, er);
      chk("aborted wr 0x14", rd, 32'h0);

      // Privileged-only instance.
      xfer(2, 1, 16'h0020, 4'hF, 32'hCAFEF00D, 3'b001, rd, er);
      chk("priv wr err", 32'(er), 32'h0);
      xfer(2, 1, 16'h0020, 4'hF, 32'h00000000, 3'b000, rd, er);
      chk("unpriv wr err", 32'(er), 32'h1);
      xfer(2, 0, 16'h0020, 4'h0, 32'h0, 3'b001, rd, er);
      chk("priv rd 0x20", rd, 32'hCAFEF00D);
      xfer(2, 0, 16'h0020, 4'h0, 32'h0, 3'b000, rd, er);
      chk("unpriv rd err", 32'(er), 32'h1);
      chk("unpriv rd data", rd, 32'h0);

      // Reset during the access phase of a 3-wait-state write.
      xfer(1, 0, 16'h0010, 4'h0, 32'h0, 3'b001, rd, er);
      start_write_k1(16'h0008, 32'hABCDEF01);
      PRESETn = 1'b0;
      psel[1] = 1'b0; penable[1] = 1'b0;
      for (int k = 0; k < 3; k++)
         for (int w = 0; w < 64; w++) mem_m[k][w] = 32'h0;
      #1;
      chk("mid-reset prdata1", prdata[1], 32'h0);
      chk("mid-reset prdata0", prdata[0], 32'h0);
      chk("mid-reset pready1", 32'(pready[1]), 32'h0);
      @(posedge PCLK);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      xfer(1, 0, 16'h0008, 4'h0, 32'h0, 3'b001, rd, er);
      chk("post-reset rd 0x8", rd, 32'h0);
      xfer(1, 0, 16'h0010, 4'h0, 32'h0, 3'b001, rd, er);
      chk("post-reset rd 0x10", rd, 32'h0);
      xfer(0, 0, 16'h000C, 4'h0, 32'h0, 3'b001, rd, er);
      chk("post-reset k0 rd 0xC", rd, 32'h0);

      repeat (2) @(posedge PCLK);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb4_slave_regfile.md
# apb4_slave_regfile

Synthesizable APB4 completer backed by a word-organised register array, the responder counterpart to the team's APB4 master bus functional model. It answers PSEL/PENABLE transfers with a configurable number of wait states, honours PSTRB byte strobes on writes, and flags out-of-range, misaligned and privilege-violating accesses through PSLVERR. It sits on an APB4 segment behind an AHB3-Lite-to-APB4 bridge. It also serves as the default target when the master BFM is exercised in simulation.

## Interface
- PADDR_SIZE, 16: address width in bits.
- PDATA_SIZE, 32: data width in bits; must be 8, 16, 32 or 64.
- MEM_WORDS, 64: number of PDATA_SIZE-wide words; must be a power of 2, minimum 2.
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase; range 0..15.
- PRIV_ONLY, 0: when 1, accesses with PPROT[0]=0 (unprivileged) are rejected with an error.

- PCLK  in  1  bus clock; all state changes on the rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PSTRB  in  PDATA_SIZE/8  write byte strobes; ignored on reads.
- PADDR  in  PADDR_SIZE  byte address.
- PPROT  in  3  protection type; only bit 0 is used.
- PWDATA  in  PDATA_SIZE  write data.
- PRDATA  out  PDATA_SIZE  read data; valid when PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- Reset: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, wait counter=0, all array words=0. All outputs are registered.
- Let BL = log2(PDATA_SIZE/8) and WL = log2(MEM_WORDS).
- Word index = PADDR[BL +: WL].
- An access is in error if any of the following holds:
  - PADDR[BL-1:0] != 0 (misaligned);
  - PADDR >= MEM_WORDS*PDATA_SIZE/8 (out of range);
  - PRIV_ONLY=1 and PPROT[0]=0 (unprivileged).
- FSM states and transitions:
  - IDLE: on PSEL=1 and PENABLE=0 (setup cycle), go to ACCESS. On that edge:
    - load counter with WAIT_STATES;
    - latch the error flag;
    - PREADY <= (WAIT_STATES==0);
    - PSLVERR <= err and (WAIT_STATES==0);
    - PRDATA <= err or PWRITE ? 0 : array[index].
  - ACCESS, counter != 0: decrement the counter. When the counter reaches 1, PREADY <= 1 and PSLVERR <= latched err on the same edge.
  - ACCESS, PREADY=1 with PSEL=1 and PENABLE=1: the transfer completes on this edge.
    - If it is a write without error, write each byte lane i where PSTRB[i]=1 from PWDATA.
    - PREADY <= 0, PSLVERR <= 0, go to IDLE.
    - The next cycle may be a new setup cycle; back-to-back transfers are supported.
  - ACCESS, PSEL=0 (protocol abort): go to IDLE, no write, PREADY <= 0, PSLVERR <= 0.
- A write with error never modifies the array. A read with error returns PRDATA=0.
- A write with PSTRB=0 completes normally and changes nothing.
- PWRITE, PADDR, PSTRB and PWDATA are sampled at the completing edge; APB4 requires them to be stable across the transfer.
- PRDATA holds its value after completion until the next setup cycle.

## Timing
- Transfer length = 2 + WAIT_STATES cycles (setup cycle, then access cycles).
- PREADY is high for exactly one cycle per transfer: the final access cycle.
- Read data appears together with PREADY. There is no extra read latency; the array is sampled at the end of the setup cycle.
- A write is visible to a read whose setup cycle starts on the cycle after the write completes.
- PRESETn assertion mid-transfer: all outputs return to reset values asynchronously, the array is cleared, and the pending write is lost. After release, the block waits in IDLE for a fresh setup cycle.

## Test plan
- Reset, then a read of 0x0000 with WAIT_STATES=0 → PREADY=1 in the 2nd cycle, PRDATA=0x00000000, PSLVERR=0.
- Write 0x0004 with data 0xDEADBEEF and PSTRB=4'b0101, then read 0x0004 → PRDATA=0x00AD00EF.
- WAIT_STATES=3: write to 0x0010, then read it back → PREADY low for 3 access cycles, high in cycle 5 of each transfer, data matches.
- Error cases, each → PREADY=1 and PSLVERR=1:
  - write 0x0100 (out of range for 64x32);
  - read 0x0002 (misaligned);
  - with PRIV_ONLY=1, write with PPROT=3'b000.
  - Follow-up reads confirm the array is unchanged and error reads return 0.
- Assert PRESETn low during the access phase of a 3-wait-state write to 0x0008 → outputs return to 0 immediately; a later read of 0x0008 returns 0.
- Back-to-back write 0x000C then read 0x000C with no idle cycle → the read returns the just-written data.
